// File: rtl/alu_pkg.sv
// Opcode encodings, FSM states and op classification shared by the alu_iter slice.
// Build option: ALU_ITER_DIV_EN enables the iterative unsigned divider (divu/remu).
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Without the divider, divu/remu fall back to the single-cycle path (result 0).
  function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_ITER_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-cycle shift-add multiplier and restoring unsigned divider.
// Build option: ALU_ITER_DIV_EN adds the divider; otherwise only mul is built.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc, acc_nx;   // product accumulator, or partial remainder
  logic [WIDTH-1:0] opb, opb_nx;   // shifted multiplicand, or divisor
  logic [WIDTH-1:0] q, q_nx;       // multiplier / dividend shifting into quotient

`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0] rem_sh, diff;
`endif

  always_comb begin
    acc_nx = acc;
    opb_nx = opb;
    q_nx   = q;
`ifdef ALU_ITER_DIV_EN
    rem_sh = '0;
    diff   = '0;
`endif
    if (op_q == OP_MUL) begin
      acc_nx = acc + (q[0] ? opb : '0);
      opb_nx = opb << 1;
      q_nx   = q >> 1;
    end
`ifdef ALU_ITER_DIV_EN
    else begin
      // b==0 never borrows: quotient fills with ones and remainder rebuilds a.
      rem_sh = {acc, q[WIDTH-1]};
      diff   = rem_sh - {1'b0, opb};
      if (!diff[WIDTH]) begin
        acc_nx = diff[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign done = active && (cnt == '0);

`ifdef ALU_ITER_DIV_EN
  assign result = (op_q == OP_DIVU) ? q_nx : acc_nx;
`else
  assign result = acc_nx;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      opb    <= '0;
      q      <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      op_q   <= op;
      acc    <= '0;
      opb    <= b;
      q      <= a;
    end else if (active) begin
      acc <= acc_nx;
      opb <= opb_nx;
      q   <= q_nx;
      cnt <= cnt - CW'(1);
      if (cnt == '0) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle ops registered with latency 1, mul/divu/remu iterate WIDTH cycles.
// Build option: ALU_ITER_DIV_EN enables divu/remu hardware (see alu_iter_muldiv).
module alu_iter
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             busy
);

  state_t           state, state_nx;
  logic             accept;
  logic             iter_op;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] aluout_q;
  logic             zero_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign accept    = in_valid && in_ready;
  assign iter_op   = is_iter(alucontrol);
  assign shamt     = srcb[SHW-1:0];
  assign aluout    = aluout_q;
  assign zero      = zero_q;

  always_comb begin
    alu_res = '0;
    unique case (alucontrol)
      OP_ADD:  alu_res = srca + srcb;
      OP_SUB:  alu_res = srca - srcb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, srca < srcb};
      OP_SLL:  alu_res = srca << shamt;
      OP_XOR:  alu_res = srca ^ srcb;
      OP_SRL:  alu_res = srca >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(srca) >>> shamt);
      OP_OR:   alu_res = srca | srcb;
      OP_AND:  alu_res = srca & srcb;
      default: alu_res = '0;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && iter_op),
    .op      (alucontrol),
    .a       (srca),
    .b       (srcb),
    .done    (md_done),
    .result  (md_result)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = iter_op ? BUSY : DONE;
      BUSY: if (md_done) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aluout_q <= '0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      zero_q <= (srca == srcb);
      if (!iter_op) aluout_q <= alu_res;
    end else if ((state == BUSY) && md_done) begin
      aluout_q <= md_result;
    end
  end

endmodule
